// File: rtl/line_pkg.sv
// Shared types for the line pixel sink: coordinate widths, FSM state and point record.
package line_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic           last;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } pt_t;

  localparam int unsigned PT_W = $bits(pt_t);

  typedef enum logic [1:0] {
    CMP_AHEAD,
    CMP_EQUAL,
    CMP_BEHIND
  } cmp_t;

  // Raster order is row-major: a point is behind when its row is earlier,
  // or on the same row at an earlier column.
  function automatic cmp_t pt_compare(input pt_t p,
                                      input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y);
    cmp_t r;
    if (p.y == y && p.x == x)
      r = CMP_EQUAL;
    else if (p.y < y || (p.y == y && p.x < x))
      r = CMP_BEHIND;
    else
      r = CMP_AHEAD;
    return r;
  endfunction

endpackage

// File: rtl/line_pt_fifo.sv
// In-order point FIFO with synchronous reset and single-cycle flush.
module line_pt_fifo
  import line_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  pt_t  din_i,
  input  logic pop_i,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  output pt_t  head_o
);

  pt_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q,    cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i)
      mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/line_pixel_sink.sv
// Matches queued line points against the raster and flags on-line pixels.
// Define LINE_SINK_MISS_CNT_EN to add the miss_cnt output (dropped-point count).
module line_pixel_sink
  import line_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] x_cnt,
  input  logic [Y_W-1:0] y_cnt,
  input  logic           pt_valid,
  input  logic [X_W-1:0] pt_x,
  input  logic [Y_W-1:0] pt_y,
  input  logic           pt_last,
  output logic           pt_ready,
  output logic           pixel_on,
  output logic           frame_done,
  output logic           frame_abort
`ifdef LINE_SINK_MISS_CNT_EN
  ,
  output logic [15:0]    miss_cnt
`endif
);

  state_t state_q;
  logic   entry_q;
  logic   pixel_on_q, frame_done_q, frame_abort_q;

  logic   at_origin;
  logic   fifo_full, fifo_empty;
  pt_t    head, din;
  cmp_t   cmp;
  logic   push, pop, flush, match, drop;

  assign at_origin = (x_cnt == '0) && (y_cnt == '0);
  assign din       = '{last: pt_last, y: pt_y, x: pt_x};
  assign cmp       = pt_compare(head, x_cnt, y_cnt);
  assign pt_ready  = !fifo_full && (state_q != ST_DONE);
  assign push      = pt_valid && pt_ready;

  // A point offered on the abort cycle is accepted but discarded by the flush.
  always_comb begin
    pop   = 1'b0;
    flush = 1'b0;
    match = 1'b0;
    drop  = 1'b0;
    if (state_q == ST_SCAN) begin
      if (at_origin && !entry_q) begin
        flush = 1'b1;
      end else if (!fifo_empty) begin
        case (cmp)
          CMP_EQUAL: begin
            pop   = 1'b1;
            match = 1'b1;
          end
          CMP_BEHIND: begin
            pop  = 1'b1;
            drop = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  line_pt_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .flush_i (flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      entry_q       <= 1'b0;
      pixel_on_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      pixel_on_q    <= match;
      frame_done_q  <= pop && head.last;
      frame_abort_q <= flush;
      entry_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (at_origin) begin
            state_q <= ST_SCAN;
            entry_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (flush)
            state_q <= ST_IDLE;
          else if (pop && head.last)
            state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (at_origin)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pixel_on    = pixel_on_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

`ifdef LINE_SINK_MISS_CNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      miss_cnt_q <= '0;
    else if (state_q == ST_IDLE && at_origin)
      miss_cnt_q <= '0;
    else if (drop && miss_cnt_q != '1)
      miss_cnt_q <= miss_cnt_q + 16'd1;
  end

  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_line_pixel_sink.sv
// Directed, table-driven bench for line_pixel_sink (DEPTH=16).
module tb_line_pixel_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        pt_valid;
  logic [10:0] pt_x;
  logic [9:0]  pt_y;
  logic        pt_last;
  logic        pt_ready;
  logic        pixel_on;
  logic        frame_done;
  logic        frame_abort;
`ifdef LINE_SINK_MISS_CNT_EN
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_pixel_sink #(.DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt),
    .pt_valid    (pt_valid),
    .pt_x        (pt_x),
    .pt_y        (pt_y),
    .pt_last     (pt_last),
    .pt_ready    (pt_ready),
    .pixel_on    (pixel_on),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
`ifdef LINE_SINK_MISS_CNT_EN
    ,
    .miss_cnt    (miss_cnt)
`endif
  );

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        v;
    logic [10:0] px;
    logic [9:0]  py;
    logic        pl;
    logic        pix;
    logic        fd;
    logic        fa;
    logic        rdy;
    logic [15:0] miss;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];

  function automatic vec_t mk(input int x, input int y, input bit v,
                              input int px, input int py, input bit pl,
                              input bit pix, input bit fd, input bit fa,
                              input bit rdy, input int miss);
    vec_t r;
    r.x = 11'(x);  r.y = 10'(y);  r.v = v;
    r.px = 11'(px); r.py = 10'(py); r.pl = pl;
    r.pix = pix; r.fd = fd; r.fa = fa; r.rdy = rdy; r.miss = 16'(miss);
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic [10:0] x, input logic [9:0] y, input logic v,
                      input logic [10:0] px, input logic [9:0] py, input logic pl);
    @(negedge clk);
    x_cnt = x; y_cnt = y; pt_valid = v; pt_x = px; pt_y = py; pt_last = pl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; pt_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input int idx, input logic pix,
                          input logic fd, input logic fa, input logic rdy);
    chk({tag, ".pixel_on"}, idx, 16'(pixel_on), 16'(pix));
    chk({tag, ".frame_done"}, idx, 16'(frame_done), 16'(fd));
    chk({tag, ".frame_abort"}, idx, 16'(frame_abort), 16'(fa));
    chk({tag, ".pt_ready"}, idx, 16'(pt_ready), 16'(rdy));
  endtask

  initial begin
    //              x   y  v  px  py pl  pix fd fa rdy miss
    // basic three-point line
    tbl[0]  = mk(50,  9, 1,   5,  0, 0,  0, 0, 0, 1, 0);
    tbl[1]  = mk(50,  9, 1,   6,  1, 0,  0, 0, 0, 1, 0);
    tbl[2]  = mk(50,  9, 1,   7,  2, 1,  0, 0, 0, 1, 0);
    tbl[3]  = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[4]  = mk( 1,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[5]  = mk( 5,  0, 0,   0,  0, 0,  1, 0, 0, 1, 0);
    tbl[6]  = mk( 6,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[7]  = mk( 6,  1, 0,   0,  0, 0,  1, 0, 0, 1, 0);
    tbl[8]  = mk( 7,  2, 0,   0,  0, 0,  1, 1, 0, 0, 0);
    tbl[9]  = mk( 8,  2, 1,   1,  1, 0,  0, 0, 0, 0, 0);
    tbl[10] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    // late point dropped, then last point matched
    tbl[11] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[12] = mk( 1,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[13] = mk( 4,  0, 1,   3,  0, 0,  0, 0, 0, 1, 0);
    tbl[14] = mk( 5,  0, 1,   9,  0, 1,  0, 0, 0, 1, 1);
    tbl[15] = mk( 8,  0, 0,   0,  0, 0,  0, 0, 0, 1, 1);
    tbl[16] = mk( 9,  0, 0,   0,  0, 0,  1, 1, 0, 0, 1);
    tbl[17] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 1);
    // unfinished line aborted at frame start
    tbl[18] = mk(20,  3, 1, 100, 50, 0,  0, 0, 0, 1, 1);
    tbl[19] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[20] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[21] = mk(50, 40, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[22] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 1, 1, 0);
    tbl[23] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[24] = mk(100,50, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[25] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 1, 1, 0);
    // duplicate points, one pop per matching cycle
    tbl[26] = mk(30,  1, 1,  10,  5, 0,  0, 0, 0, 1, 0);
    tbl[27] = mk(30,  1, 1,  10,  5, 0,  0, 0, 0, 1, 0);
    tbl[28] = mk(30,  1, 1,  10,  5, 1,  0, 0, 0, 1, 0);
    tbl[29] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[30] = mk(10,  5, 0,   0,  0, 0,  1, 0, 0, 1, 0);
    tbl[31] = mk( 2,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);
    tbl[32] = mk(10,  5, 0,   0,  0, 0,  1, 0, 0, 1, 0);
    tbl[33] = mk(10,  5, 0,   0,  0, 0,  1, 1, 0, 0, 0);
    tbl[34] = mk( 0,  0, 0,   0,  0, 0,  0, 0, 0, 1, 0);

    reset = 1'b1; x_cnt = 11'd50; y_cnt = 10'd9;
    pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_last = 1'b0;
    do_reset(2);
    #1;
    chk_outs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef LINE_SINK_MISS_CNT_EN
    chk("reset.miss_cnt", 0, miss_cnt, 16'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].px, tbl[i].py, tbl[i].pl);
      chk_outs("vec", i, tbl[i].pix, tbl[i].fd, tbl[i].fa, tbl[i].rdy);
`ifdef LINE_SINK_MISS_CNT_EN
      chk("vec.miss_cnt", i, miss_cnt, tbl[i].miss);
`endif
    end

    // Fill all 16 entries, then one pop frees a slot.
    for (int i = 0; i < 16; i++) begin
      step(11'd30, 10'd1, 1'b1, 11'd200, 10'd100, 1'b0);
      chk("full.pt_ready", i, 16'(pt_ready), 16'(i < 15));
    end
    step(11'd30, 10'd1, 1'b1, 11'd1, 10'd1, 1'b1);
    chk("full.blocked", 16, 16'(pt_ready), 16'd0);
    step(11'd0, 10'd0, 1'b0, 11'd0, 10'd0, 1'b0);
    chk("full.enter_scan", 17, 16'(pt_ready), 16'd0);
    step(11'd200, 10'd100, 1'b0, 11'd0, 10'd0, 1'b0);
    chk("full.pop_pixel", 18, 16'(pixel_on), 16'd1);
    chk("full.pop_ready", 18, 16'(pt_ready), 16'd1);

    // Reset with points queued: nothing survives, no pulses.
    do_reset(1);
    chk_outs("rst_full", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++)
      step(11'd30, 10'd3, 1'b1, 11'(i), 10'd1, 1'(i == 4));
    chk("rst_mid.ready4", 4, 16'(pt_ready), 16'd1);
    step(11'd0, 10'd0, 1'b0, 11'd0, 10'd0, 1'b0);
    step(11'd1, 10'd1, 1'b0, 11'd0, 10'd0, 1'b0);
    chk("rst_mid.scan_match", 0, 16'(pixel_on), 16'd1);
    @(negedge clk);
    reset = 1'b1; pt_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("rst_mid", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step(11'd0, 10'd0, 1'b0, 11'd0, 10'd0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step(11'(i), 10'd1, 1'b0, 11'd0, 10'd0, 1'b0);
      chk_outs("rst_mid.rescan", i, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(11'd0, 10'd0, 1'b0, 11'd0, 10'd0, 1'b0);
    chk_outs("rst_mid.abort", 5, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/line_pixel_sink.md
LINE_PIXEL_SINK -- requirements
Module: line_pixel_sink

Interface
REQ-001 Parameter DEPTH, default 16, point FIFO depth; power of two, 4..64.
REQ-002 Parameter AW, default $clog2(DEPTH), FIFO address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 x_cnt  input  11  raster column counter.
REQ-006 y_cnt  input  10  raster row counter.
REQ-007 pt_valid  input  1  line point offered.
REQ-008 pt_x  input  11  point column.
REQ-009 pt_y  input  10  point row.
REQ-010 pt_last  input  1  offered point is the final point of the line.
REQ-011 pt_ready  output  1  sink accepts the point this cycle.
REQ-012 pixel_on  output  1  current raster pixel lies on the line; registered.
REQ-013 frame_done  output  1  one-cycle pulse: last point matched or dropped.
REQ-014 frame_abort  output  1  one-cycle pulse: frame start with line unfinished.

Function
REQ-015 Point transfer SHALL occur only on a cycle with pt_valid && pt_ready; pt_ready = !full, no bypass when full.
REQ-016 Accepted points SHALL be stored in order in a DEPTH-entry FIFO holding {pt_last, pt_y, pt_x}.
REQ-017 States: IDLE, SCAN, DONE; reset enters IDLE.
REQ-018 IDLE: points SHALL be accepted; leave to SCAN when x_cnt==0 && y_cnt==0.
REQ-019 SCAN, head equal to (x_cnt, y_cnt): pop head and assert pixel_on on the next cycle (latency 1).
REQ-020 SCAN, head behind raster (head_y < y_cnt, or head_y == y_cnt && head_x < x_cnt): pop head silently, pixel_on stays 0.
REQ-021 SCAN, head ahead of raster or FIFO empty: no pop; pixel_on 0 next cycle.
REQ-022 Popping an entry with pt_last set SHALL go to DONE and pulse frame_done on the next cycle.
REQ-023 DONE: pt_ready SHALL be 0; at x_cnt==0 && y_cnt==0 return to IDLE.
REQ-024 SCAN at x_cnt==0 && y_cnt==0 (except the SCAN-entry cycle): flush FIFO, pulse frame_abort, go to IDLE.
REQ-025 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-026 Coordinate comparisons SHALL be unsigned, full width; pointers wrap modulo DEPTH.
REQ-027 At most one pop per cycle; duplicate consecutive points each consume one matching raster cycle.

Reset
REQ-028 Reset SHALL clear FIFO pointers and occupancy; pixel_on, frame_done, frame_abort = 0; pt_ready = 1 the first cycle after reset.
REQ-029 Reset mid-line SHALL discard stored points without a frame_done or frame_abort pulse.

Configuration
REQ-030 Macro LINE_SINK_MISS_CNT_EN SHALL add output miss_cnt (16 bits): count of REQ-020 drops, saturating at 16'hFFFF, cleared on reset and on IDLE-to-SCAN.
REQ-031 Without LINE_SINK_MISS_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package line_pkg SHALL hold the state enum, X_W=11, Y_W=10, and the packed point struct.
REQ-033 The FIFO SHALL be the sub-module line_pt_fifo (push/pop/full/empty/head); the FSM and comparator stay in line_pixel_sink.

Verification
REQ-034 Push (5,0),(6,1),(7,2 last) in IDLE; raster starts at 0,0 -> pixel_on exactly one cycle after each of (5,0),(6,1),(7,2); frame_done after (7,2).
REQ-035 Push (3,0) after the raster passes (3,0), followed by (9,0 last) -> (3,0) dropped, pixel_on only at (9,0); miss_cnt=1 with macro.
REQ-036 Push 16 points with DEPTH=16 and no raster match -> pt_ready=0; one pop -> pt_ready=1 the next cycle.
REQ-037 Push (100,50) without pt_last; raster wraps to 0,0 -> frame_abort pulse, FIFO empty, state IDLE.
REQ-038 Assert reset while 4 points are queued -> FIFO empty, pixel_on=0, no frame_done or frame_abort.
REQ-039 Push 3 copies of (10,5) -> each copy needs its own raster pass of (10,5); pop one per pass.
